// File: rtl/seq_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Used by seq_adder_16bits and its slice adder adder_4bits.
package seq_adder_pkg;

    localparam int NIB_W         = 4;
    localparam int N_NIBBLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single-nibble build still needs a 1-bit counter.
    function automatic int cntWidth(input int nNibbles);
        return (nNibbles > 1) ? $clog2(nNibbles) : 1;
    endfunction

endpackage

// File: rtl/seq_adder_16bits_adder_4bits.sv
// One 4-bit ripple-carry slice, reused every ADD cycle by seq_adder_16bits.
module adder_4bits
    import seq_adder_pkg::*;
(
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    input  logic             i_cin,
    output logic [NIB_W-1:0] o_sum,
    output logic             o_cout
);

    always_comb begin
        logic w_carry;
        w_carry = i_cin;
        o_sum   = '0;
        for (int i = 0; i < NIB_W; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_carry;
    end

endmodule

// File: rtl/seq_adder_16bits.sv
// Nibble-serial unsigned adder: one 4-bit slice per cycle, carry kept in a register.
// Optional signed overflow output enabled by defining SEQ_ADDER_OVF_EN.
module seq_adder_16bits
    import seq_adder_pkg::*;
#(
    parameter  int N_NIBBLES = N_NIBBLES_DEF,
    localparam int W         = NIB_W * N_NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef SEQ_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int               CNT_W    = cntWidth(N_NIBBLES);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(N_NIBBLES - 1);

    state_t             r_state;
    state_t             w_stateNext;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [CNT_W-1:0]   r_nib;
    logic [NIB_W-1:0]   w_aNib;
    logic [NIB_W-1:0]   w_bNib;
    logic [NIB_W-1:0]   w_sliceSum;
    logic               w_sliceCout;
    logic               w_accept;
    logic               w_lastNib;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_lastNib = (r_nib == LAST_NIB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: if (start)     w_stateNext = ST_ADD;
            ST_ADD:  if (w_lastNib) w_stateNext = ST_DONE;
            ST_DONE:                w_stateNext = ST_IDLE;
            default:                w_stateNext = ST_IDLE;
        endcase
    end

    // Pick the current nibble of the latched operands for the shared slice adder.
    always_comb begin
        w_aNib = '0;
        w_bNib = '0;
        for (int k = 0; k < N_NIBBLES; k++) begin
            if (r_nib == CNT_W'(k)) begin
                w_aNib = r_a[k*NIB_W +: NIB_W];
                w_bNib = r_b[k*NIB_W +: NIB_W];
            end
        end
    end

    adder_4bits u_slice (
        .i_a    (w_aNib),
        .i_b    (w_bNib),
        .i_cin  (r_carry),
        .o_sum  (w_sliceSum),
        .o_cout (w_sliceCout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_nib   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_carry <= cin;
            r_cout  <= 1'b0;
            r_nib   <= '0;
        end else if (r_state == ST_ADD) begin
            for (int k = 0; k < N_NIBBLES; k++) begin
                if (r_nib == CNT_W'(k)) begin
                    r_sum[k*NIB_W +: NIB_W] <= w_sliceSum;
                end
            end
            r_carry <= w_sliceCout;
            r_nib   <= r_nib + 1'b1;
            if (w_lastNib) begin
                r_cout <= w_sliceCout;
            end
        end
    end

`ifdef SEQ_ADDER_OVF_EN
    logic r_ovf;

    // The MSB of the result is bit 3 of the final slice, so overflow is judged before it lands in r_sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if ((r_state == ST_ADD) && w_lastNib) begin
            r_ovf <= (r_a[W-1] == r_b[W-1]) && (w_sliceSum[NIB_W-1] != r_a[W-1]);
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_seq_adder_16bits.sv
// Scoreboard bench for seq_adder_16bits; expected {cout,sum} queued at start, checked at done.
// Checks ovf as well when built with SEQ_ADDER_OVF_EN.
module tb_seq_adder_16bits;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SEQ_ADDER_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sbQueue[$];
    int   testCount = 0;
    int   failCount = 0;

    seq_adder_16bits dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SEQ_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; the operation is accepted at the next rising edge.
    task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin);
        logic [W:0] full;
        exp_t       e;
        full   = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, icin};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (ia[W-1] == ib[W-1]) && (full[W-1] != ia[W-1]);
        sbQueue.push_back(e);
        a     = ia;
        b     = ib;
        cin   = icin;
        start = 1'b1;
        @(negedge clk);
        checkOutput("busyAfterAccept", 32'(busy), 32'd1);
    endtask

    task automatic waitAndCheck(input bit holdStart, input bit scramble);
        int   n;
        exp_t e;
        n = 0;
        e = '0;
        if (!holdStart) start = 1'b0;
        while (!done && n < 20) begin
            if (scramble) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n++;
        end
        checkOutput("doneEdgesAfterAccept", 32'(n), 32'd4);
        checkOutput("busyInDone", 32'(busy), 32'd1);
        checkOutput("sbDepth", 32'(sbQueue.size()), 32'd1);
        if (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
        end
        checkOutput("sum", 32'(sum), 32'(e.sum));
        checkOutput("cout", 32'(cout), 32'(e.cout));
`ifdef SEQ_ADDER_OVF_EN
        checkOutput("ovf", 32'(ovf), 32'(e.ovf));
`endif
        @(negedge clk);
        start = 1'b0;
        checkOutput("donePulseEnds", 32'(done), 32'd0);
        checkOutput("busyIdle", 32'(busy), 32'd0);
        checkOutput("sumHeld", 32'(sum), 32'(e.sum));
        checkOutput("coutHeld", 32'(cout), 32'(e.cout));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("resetSum", 32'(sum), 32'd0);
        checkOutput("resetCout", 32'(cout), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        rst_n = 1'b1;

        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        waitAndCheck(1'b0, 1'b0);

        applyStimulus(16'h1234, 16'h4321, 1'b1);
        waitAndCheck(1'b1, 1'b0);

        // Abort an add after two nibbles have been written.
        applyStimulus(16'h1111, 16'h2222, 1'b1);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetSum", 32'(sum), 32'd0);
        checkOutput("midResetCout", 32'(cout), 32'd0);
        checkOutput("midResetBusy", 32'(busy), 32'd0);
        checkOutput("midResetDone", 32'(done), 32'd0);
        sbQueue.delete();
        #2;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checkOutput("noDoneAfterReset", 32'(done), 32'd0);
            checkOutput("noBusyAfterReset", 32'(busy), 32'd0);
        end

        applyStimulus(16'h0005, 16'h0003, 1'b0);
        waitAndCheck(1'b0, 1'b0);

        applyStimulus(16'h7FFF, 16'h0001, 1'b0);
        waitAndCheck(1'b0, 1'b0);
        applyStimulus(16'h8000, 16'hFFFF, 1'b0);
        waitAndCheck(1'b0, 1'b0);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
        waitAndCheck(1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            waitAndCheck(1'b0, 1'b1);
        end

        for (int i = 0; i < 10000; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            waitAndCheck(1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
